// File: rtl/pusch_pkg.sv
// Shared PUSCH types and widths.
// Holds the scrambler controller state encoding and c_init helpers.
package pusch_pkg;

   localparam int CINIT_W = 31;
   localparam int RNTI_W  = 16;
   localparam int NID_W   = 10;

   typedef enum logic [2:0] {
      SC_IDLE,
      SC_LOAD,
      SC_WARM,
      SC_RUN,
      SC_FIN
   } sc_ctrl_state_t;

   // c_init = n_RNTI * 2^15 + n_ID; the sum never reaches bit 31.
   function automatic logic [CINIT_W-1:0] calc_cinit(
      input logic [RNTI_W-1:0] rnti,
      input logic [NID_W-1:0]  nid
   );
      logic [CINIT_W-1:0] hi;
      logic [CINIT_W-1:0] lo;
      hi = {rnti, 15'b0};
      lo = {{(CINIT_W-NID_W){1'b0}}, nid};
      return hi + lo;
   endfunction

endpackage

// File: rtl/scrambler_ctrl.sv
// Sequences one PUSCH codeword through the gold generator and scrambler.
// Optional abort path: define SC_CTRL_ABORT_EN to add ABORT/ABORTED.
module scrambler_ctrl
   import pusch_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic                CLK_SC,
   input  logic                RST_SC,
   input  logic                START,
   input  logic [RNTI_W-1:0]   CFG_RNTI,
   input  logic [NID_W-1:0]    CFG_NID,
   input  logic [LEN_W-1:0]    CFG_LEN,
   input  logic                GOLD_VALID,
   input  logic                IL_VALID,
`ifdef SC_CTRL_ABORT_EN
   input  logic                ABORT,
   output logic                ABORTED,
`endif
   output logic                GOLD_LOAD,
   output logic [CINIT_W-1:0]  GOLD_CINIT,
   output logic                GOLD_ADV,
   output logic                IL_READY,
   output logic                SC_BUSY_OUT,
   output logic                DONE
);

   sc_ctrl_state_t state;
   sc_ctrl_state_t state_nxt;

   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt;
   logic [CINIT_W-1:0] cinit_q;

   logic accept;
   logic fire;
   logic last;
   logic busy;
   logic load;
   logic done;
   logic abort_req;
   logic abort_hit;

`ifdef SC_CTRL_ABORT_EN
   assign abort_req = ABORT;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      fire      = 1'b0;
      last      = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      done      = 1'b0;
      abort_hit = 1'b0;
      unique case (state)
         SC_IDLE: begin
            if (START) begin
               accept    = 1'b1;
               state_nxt = (CFG_LEN == '0) ? SC_FIN : SC_LOAD;
            end
         end
         SC_LOAD: begin
            load = 1'b1;
            if (abort_req) begin
               abort_hit = 1'b1;
               state_nxt = SC_FIN;
            end else begin
               state_nxt = SC_WARM;
            end
         end
         SC_WARM: begin
            if (abort_req) begin
               abort_hit = 1'b1;
               state_nxt = SC_FIN;
            end else if (GOLD_VALID) begin
               state_nxt = SC_RUN;
            end
         end
         SC_RUN: begin
            busy = 1'b1;
            // Abort wins over the final bit: nothing is consumed that cycle.
            if (abort_req) begin
               abort_hit = 1'b1;
               state_nxt = SC_FIN;
            end else begin
               fire = IL_VALID & GOLD_VALID;
               if (fire && cnt == len_q - LEN_W'(1)) begin
                  last      = 1'b1;
                  state_nxt = SC_FIN;
               end
            end
         end
         SC_FIN: begin
            done      = 1'b1;
            state_nxt = SC_IDLE;
         end
         default: begin
            state_nxt = SC_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_SC or negedge RST_SC) begin
      if (!RST_SC) begin
         state <= SC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge CLK_SC or negedge RST_SC) begin
      if (!RST_SC) begin
         len_q   <= '0;
         cinit_q <= '0;
      end else if (accept) begin
         len_q   <= CFG_LEN;
         cinit_q <= calc_cinit(CFG_RNTI, CFG_NID);
      end
   end

   always_ff @(posedge CLK_SC or negedge RST_SC) begin
      if (!RST_SC) begin
         cnt <= '0;
      end else if (accept || last || abort_hit) begin
         cnt <= '0;
      end else if (fire) begin
         cnt <= cnt + LEN_W'(1);
      end
   end

`ifdef SC_CTRL_ABORT_EN
   always_ff @(posedge CLK_SC or negedge RST_SC) begin
      if (!RST_SC) begin
         ABORTED <= 1'b0;
      end else if (accept) begin
         ABORTED <= 1'b0;
      end else if (abort_hit) begin
         ABORTED <= 1'b1;
      end
   end
`endif

   assign GOLD_LOAD   = load;
   assign GOLD_CINIT  = cinit_q;
   assign GOLD_ADV    = fire;
   assign IL_READY    = fire;
   assign SC_BUSY_OUT = busy;
   assign DONE        = done;

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed bench for scrambler_ctrl.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_scrambler_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] rnti;
   logic [9:0]  nid;
   logic [15:0] len;
   logic        gold_valid;
   logic        il_valid;
   logic        gold_load;
   logic [30:0] gold_cinit;
   logic        gold_adv;
   logic        il_ready;
   logic        busy;
   logic        done;
`ifdef SC_CTRL_ABORT_EN
   logic        abort;
   logic        aborted;
`endif

   int checks = 0;
   int errors = 0;

   scrambler_ctrl #(.LEN_W(16)) dut (
      .CLK_SC      (clk),
      .RST_SC      (rst_n),
      .START       (start),
      .CFG_RNTI    (rnti),
      .CFG_NID     (nid),
      .CFG_LEN     (len),
      .GOLD_VALID  (gold_valid),
      .IL_VALID    (il_valid),
`ifdef SC_CTRL_ABORT_EN
      .ABORT       (abort),
      .ABORTED     (aborted),
`endif
      .GOLD_LOAD   (gold_load),
      .GOLD_CINIT  (gold_cinit),
      .GOLD_ADV    (gold_adv),
      .IL_READY    (il_ready),
      .SC_BUSY_OUT (busy),
      .DONE        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one codeword from IDLE and gathers what the DUT did.
   task automatic run_cw(
      input  logic [15:0] r,
      input  logic [9:0]  n,
      input  logic [15:0] l,
      input  logic [31:0] il_pat,
      input  int          gd_lo,
      input  int          gd_hi,
      output int          fires,
      output int          advs,
      output int          loads,
      output int          busy_n,
      output int          bad,
      output int          dones,
      output int          last_fire,
      output int          done_at,
      output logic [30:0] cinit_seen,
      output bit          tmo
   );
      fires = 0; advs = 0; loads = 0; busy_n = 0; bad = 0;
      dones = 0; last_fire = -1; done_at = -1; cinit_seen = '0;
      tmo = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         start = (c == 0);
         if (c == 0) begin
            rnti = r; nid = n; len = l;
         end
         il_valid   = il_pat[c % 32];
         gold_valid = !(c >= gd_lo && c <= gd_hi);
         #1;
         if (il_ready) begin
            fires++;
            last_fire = c;
            if (!(il_valid && gold_valid)) bad++;
         end
         if (gold_adv) advs++;
         if (gold_adv !== il_ready) bad++;
         if (gold_load) begin
            loads++;
            cinit_seen = gold_cinit;
         end
         if (busy) busy_n++;
         if (done) begin
            dones++;
            done_at = c;
         end
         if (dones > 0 && c > done_at) begin
            tmo = 1'b0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({gold_load, gold_adv, il_ready, busy, done} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outs got %b want 00000",
                  {gold_load, gold_adv, il_ready, busy, done});
      end
      checks++;
      if (gold_cinit !== 31'd0) begin
         errors++;
         $display("FAIL reset_cinit got %h want 0", gold_cinit);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({gold_load, busy, done} !== 3'b0) begin
         errors++;
         $display("FAIL idle_outs got %b want 000", {gold_load, busy, done});
      end
   endtask

   task automatic test_basic();
      int f, a, ld, bz, bad, dn, lf, da;
      logic [30:0] ci;
      bit tmo;
      run_cw(16'h1234, 10'd5, 16'd8, 32'hFFFF_FFFF, -1, -2,
             f, a, ld, bz, bad, dn, lf, da, ci, tmo);
      checks++;
      if (tmo) begin
         errors++;
         $display("FAIL basic_timeout got no DONE want DONE");
      end
      checks++;
      if (f !== 8 || a !== 8) begin
         errors++;
         $display("FAIL basic_fires got %0d/%0d want 8/8", f, a);
      end
      checks++;
      if (ld !== 1 || ci !== 31'h091A_0005) begin
         errors++;
         $display("FAIL basic_load got %0d cinit %h want 1 091a0005", ld, ci);
      end
      checks++;
      if (dn !== 1 || da - lf !== 1) begin
         errors++;
         $display("FAIL basic_done got %0d lat %0d want 1 lat 1", dn, da - lf);
      end
      checks++;
      if (bz !== 8 || bad !== 0) begin
         errors++;
         $display("FAIL basic_busy got %0d bad %0d want 8 bad 0", bz, bad);
      end
   endtask

   task automatic test_stalls();
      int f, a, ld, bz, bad, dn, lf, da;
      logic [30:0] ci;
      bit tmo;
      run_cw(16'hFFFF, 10'h3FF, 16'd16, 32'hA5C3_96E1, 6, 8,
             f, a, ld, bz, bad, dn, lf, da, ci, tmo);
      checks++;
      if (tmo || dn !== 1) begin
         errors++;
         $display("FAIL stall_done got %0d tmo %0d want 1 tmo 0", dn, tmo);
      end
      checks++;
      if (f !== 16 || a !== 16) begin
         errors++;
         $display("FAIL stall_fires got %0d/%0d want 16/16", f, a);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL stall_gating got %0d want 0", bad);
      end
      checks++;
      if (ci !== 31'h7FFF_83FF) begin
         errors++;
         $display("FAIL stall_cinit got %h want 7fff83ff", ci);
      end
   endtask

   task automatic test_zero_len();
      int f, a, ld, bz, bad, dn, lf, da;
      logic [30:0] ci;
      bit tmo;
      run_cw(16'h0042, 10'd1, 16'd0, 32'hFFFF_FFFF, -1, -2,
             f, a, ld, bz, bad, dn, lf, da, ci, tmo);
      checks++;
      if (tmo || dn !== 1 || da !== 1) begin
         errors++;
         $display("FAIL zero_done got %0d at %0d want 1 at 1", dn, da);
      end
      checks++;
      if (ld !== 0 || bz !== 0 || f !== 0) begin
         errors++;
         $display("FAIL zero_quiet got ld %0d bz %0d f %0d want 0 0 0",
                  ld, bz, f);
      end
   endtask

   task automatic test_back_to_back();
      int fires = 0;
      int fires_a = -1;
      int dones = 0;
      int last_done = -1;
      int loads = 0;
      logic [30:0] ci_a = '0;
      logic [30:0] ci_b = '0;
      logic [30:0] ci_mid = '0;
      bit tmo = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         start = (c == 0 || c == 4 || c == 8);
         if (c < 4) begin
            rnti = 16'h0001; nid = 10'd0; len = 16'd4;
         end else begin
            rnti = 16'h0002; nid = 10'd3; len = 16'd2;
         end
         il_valid   = 1'b1;
         gold_valid = 1'b1;
         #1;
         if (il_ready) fires++;
         if (gold_load) begin
            loads++;
            if (loads == 1) ci_a = gold_cinit;
            else ci_b = gold_cinit;
         end
         if (c == 6) ci_mid = gold_cinit;
         if (done) begin
            dones++;
            last_done = c;
            if (dones == 1) fires_a = fires;
         end
         if (dones == 2 && c > last_done) begin
            tmo = 1'b0;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (tmo) begin
         errors++;
         $display("FAIL b2b_timeout got %0d dones want 2", dones);
      end
      checks++;
      if (fires_a !== 4 || fires !== 6) begin
         errors++;
         $display("FAIL b2b_fires got %0d/%0d want 4/6", fires_a, fires);
      end
      checks++;
      if (ci_a !== 31'h0000_8000 || ci_mid !== 31'h0000_8000) begin
         errors++;
         $display("FAIL b2b_cinit_a got %h/%h want 00008000", ci_a, ci_mid);
      end
      checks++;
      if (loads !== 2 || ci_b !== 31'h0001_0003) begin
         errors++;
         $display("FAIL b2b_cinit_b got %0d %h want 2 00010003", loads, ci_b);
      end
   endtask

   task automatic test_reset_mid_run();
      int f = 0;
      int dn = 0;
      int ld = 0;
      int bz = 0;
      int f2, a2, ld2, bz2, bad2, dn2, lf2, da2;
      logic [30:0] ci2;
      bit tmo2;
      for (int c = 0; c < 50 && f < 5; c++) begin
         @(negedge clk);
         start = (c == 0);
         rnti = 16'h00AA; nid = 10'd7; len = 16'd10;
         il_valid = 1'b1;
         gold_valid = 1'b1;
         #1;
         if (il_ready) f++;
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({gold_load, gold_adv, il_ready, busy, done} !== 5'b0 ||
          gold_cinit !== 31'd0) begin
         errors++;
         $display("FAIL rst_mid_outs got %b %h want 00000 0",
                  {gold_load, gold_adv, il_ready, busy, done}, gold_cinit);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (done) dn++;
         if (gold_load) ld++;
         if (busy) bz++;
      end
      checks++;
      if (dn !== 0 || ld !== 0 || bz !== 0) begin
         errors++;
         $display("FAIL rst_mid_quiet got dn %0d ld %0d bz %0d want 0 0 0",
                  dn, ld, bz);
      end
      run_cw(16'h0001, 10'd1, 16'd3, 32'hFFFF_FFFF, -1, -2,
             f2, a2, ld2, bz2, bad2, dn2, lf2, da2, ci2, tmo2);
      checks++;
      if (tmo2 || f2 !== 3 || dn2 !== 1) begin
         errors++;
         $display("FAIL rst_mid_after got %0d fires %0d dones want 3 1",
                  f2, dn2);
      end
   endtask

`ifdef SC_CTRL_ABORT_EN
   task automatic test_abort();
      int f = 0;
      bit seen_done = 1'b0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         start = (c == 0);
         rnti = 16'h0003; nid = 10'd9; len = 16'd4;
         il_valid = 1'b1;
         gold_valid = 1'b1;
         abort = (c == 6);
         #1;
         if (il_ready) f++;
         if (c == 7) begin
            seen_done = done;
            checks++;
            if (done !== 1'b1 || aborted !== 1'b1) begin
               errors++;
               $display("FAIL abort_done got %b%b want 11", done, aborted);
            end
         end
      end
      abort = 1'b0;
      checks++;
      if (f !== 3 || !seen_done) begin
         errors++;
         $display("FAIL abort_fires got %0d want 3", f);
      end
      @(negedge clk);
      start = 1'b1;
      len = 16'd1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checks++;
      if (aborted !== 1'b0) begin
         errors++;
         $display("FAIL abort_clear got %b want 0", aborted);
      end
      repeat (6) @(negedge clk);
   endtask
`endif

   initial begin
      start = 1'b0;
      rnti = '0;
      nid = '0;
      len = '0;
      gold_valid = 1'b0;
      il_valid = 1'b0;
`ifdef SC_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_basic();
      test_stalls();
      test_zero_len();
      test_back_to_back();
      test_reset_mid_run();
`ifdef SC_CTRL_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
